// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// datapath mux selects and the packed control word.
package mips_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Purely combinational state -> control word decoder (Moore outputs).
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  output logic [CTRL_W-1:0]  o_ctrl
);

  ctrl_t w_ctrl;

  always_comb begin
    w_ctrl = '0;
    case (state_e'(i_state))
      S_FETCH: begin
        w_ctrl.ir_write  = 1'b1;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
      end
      S_DECODE:   w_ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD:    w_ctrl.iord = 1'b1;
      S_MEMWB: begin
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_SUB;
        w_ctrl.pc_src    = PCSRC_ALUOUT;
        w_ctrl.branch    = 1'b1;
      end
      S_ADDIEXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB:   w_ctrl.reg_write = 1'b1;
      S_JUMP: begin
        w_ctrl.pc_src   = PCSRC_JUMP;
        w_ctrl.pc_write = 1'b1;
      end
      default:    w_ctrl = '0;
    endcase
  end

  assign o_ctrl = w_ctrl;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core.
// Optional MIPS_CTRL_MEM_WAIT_EN adds MemReady wait states on memory accesses.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [OP_W-1:0]    Opcode,
`ifdef MIPS_CTRL_MEM_WAIT_EN
  input  logic               MemReady,
`endif
  output logic               PCWrite,
  output logic               Branch,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  state_e              r_state;
  state_e              w_next;
  logic                w_mem_ready;
  logic [CTRL_W-1:0]   w_ctrl_bits;
  ctrl_t               w_ctrl;

`ifdef MIPS_CTRL_MEM_WAIT_EN
  assign w_mem_ready = MemReady;
`else
  assign w_mem_ready = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Memory-access states stall in place until the memory reports ready.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWR:    w_next = w_mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_ADDIEXEC: w_next = S_ADDIWB;
      S_ADDIWB:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .i_state (STATE_W'(r_state)),
    .o_ctrl  (w_ctrl_bits)
  );

  // Fetch strobes are held back until the instruction word is actually there,
  // so the PC advances exactly once per fetch.
  always_comb begin
    w_ctrl = ctrl_t'(w_ctrl_bits);
    if ((r_state == S_FETCH) && !w_mem_ready) begin
      w_ctrl.ir_write = 1'b0;
      w_ctrl.pc_write = 1'b0;
    end
    PCWrite   = w_ctrl.pc_write;
    Branch    = w_ctrl.branch;
    IorD      = w_ctrl.iord;
    MemWrite  = w_ctrl.mem_write;
    IRWrite   = w_ctrl.ir_write;
    MemtoReg  = w_ctrl.mem_to_reg;
    RegDst    = w_ctrl.reg_dst;
    RegWrite  = w_ctrl.reg_write;
    ALUSrcA   = w_ctrl.alu_src_a;
    ALUSrcB   = w_ctrl.alu_src_b;
    ALUOp     = w_ctrl.alu_op;
    PCSrc     = w_ctrl.pc_src;
    IllegalOp = (r_state == S_DECODE) && !op_supported(Opcode);
    State     = STATE_W'(r_state);
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus queues the expected
// per-cycle state and control vector, a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic [5:0] Opcode;
`ifdef MIPS_CTRL_MEM_WAIT_EN
  logic       MemReady;
`endif
  logic       PCWrite, Branch, IorD, MemWrite, IRWrite, MemtoReg, RegDst;
  logic       RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;

  mips_multicycle_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Opcode    (Opcode),
`ifdef MIPS_CTRL_MEM_WAIT_EN
    .MemReady  (MemReady),
`endif
    .PCWrite   (PCWrite),
    .Branch    (Branch),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .MemtoReg  (MemtoReg),
    .RegDst    (RegDst),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSrc     (PCSrc),
    .IllegalOp (IllegalOp),
    .State     (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // {PCWrite,Branch,IorD,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
  //  ALUSrcB,ALUOp,PCSrc,IllegalOp}
  logic [15:0] act;
  assign act = {PCWrite, Branch, IorD, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp};

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [15:0] mk(input logic pcw, input logic br,
      input logic iord, input logic mw, input logic irw, input logic m2r,
      input logic rd, input logic rw, input logic sa, input logic [1:0] sb,
      input logic [1:0] op, input logic [1:0] pcs);
    return {pcw, br, iord, mw, irw, m2r, rd, rw, sa, sb, op, pcs, 1'b0};
  endfunction

  // Hand-written golden decode table.
  function automatic logic [15:0] ctl_of(input logic [3:0] s);
    case (s)
      4'd0:  return mk(1,0,0,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00);
      4'd1:  return mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
      4'd2:  return mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
      4'd3:  return mk(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
      4'd4:  return mk(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00);
      4'd5:  return mk(0,0,1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
      4'd6:  return mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
      4'd7:  return mk(0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00);
      4'd8:  return mk(0,1,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
      4'd9:  return mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
      4'd10: return mk(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00);
      4'd11: return mk(1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10);
      default: return 16'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total = total + 1;
    if (a !== e) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Queue the state sequence of one instruction, then let it run to completion.
  task automatic issue(input logic [5:0] op, input int n, input logic [23:0] seq,
                       input logic ill);
    exp_t e;
    Opcode = op;
    for (int i = 0; i < n; i++) begin
      e.st  = seq[23-4*i -: 4];
      e.ctl = ctl_of(e.st);
      if (ill && e.st == 4'd1) e.ctl[0] = 1'b1;
      q.push_back(e);
    end
    repeat (n) @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", 32'(State), 32'(e.st));
      chk("ctrl", 32'(act), 32'(e.ctl));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    Reset_n = 1'b0;
    Opcode  = 6'd0;
`ifdef MIPS_CTRL_MEM_WAIT_EN
    MemReady = 1'b1;
`endif
    #2;
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_ctrl", 32'(act), 32'(ctl_of(4'd0)));
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    issue(6'b100011, 5, 24'h012340, 1'b0);  // LW
    issue(6'b101011, 4, 24'h012500, 1'b0);  // SW
    issue(6'b000000, 4, 24'h016700, 1'b0);  // R-type
    issue(6'b000100, 3, 24'h018000, 1'b0);  // BEQ
    issue(6'b000010, 3, 24'h01B000, 1'b0);  // J
    issue(6'b001000, 4, 24'h019A00, 1'b0);  // ADDI
    issue(6'b111111, 2, 24'h010000, 1'b1);  // illegal
    issue(6'b000010, 3, 24'h01B000, 1'b0);  // recovers after illegal

    // Async reset in the middle of an R-type EXECUTE.
    Opcode = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      e.st  = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : 4'd6;
      e.ctl = ctl_of(e.st);
      q.push_back(e);
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("abort_state", 32'(State), 32'd0);
    chk("abort_irwrite", 32'(IRWrite), 32'd1);
    chk("abort_pcwrite", 32'(PCWrite), 32'd1);
    chk("abort_regwrite", 32'(RegWrite), 32'd0);
    @(posedge Clk);
    #1;
    chk("abort_hold", 32'(State), 32'd0);
    Reset_n = 1'b1;

    issue(6'b100011, 5, 24'h012340, 1'b0);  // LW after abort

`ifdef MIPS_CTRL_MEM_WAIT_EN
    // Fetch stalls for three cycles with PC/IR writes suppressed.
    Opcode   = 6'b000010;
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e.st  = 4'd0;
      e.ctl = ctl_of(4'd0) & ~16'h8800;
      q.push_back(e);
    end
    repeat (3) @(posedge Clk);
    #1;
    MemReady = 1'b1;
    issue(6'b000010, 3, 24'h01B000, 1'b0);
`endif

    @(negedge Clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
